// File: rtl/bf16_pkg.sv
// Shared BF16 definitions for the sequential subtractor and its companions.
//   - field widths and special-value encodings
//   - FSM state encoding for bf16_sub_seq
//   - flag bundle and per-operand classification structs
//   - is_nan() helper
package bf16_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 7;

  localparam logic [15:0]      BF16_QNAN = 16'h7FC0;
  localparam logic [15:0]      BF16_PINF = 16'h7F80;
  localparam logic [15:0]      BF16_NINF = 16'hFF80;
  localparam logic [EXP_W-1:0] EXP_MAX   = 8'hFF;

  typedef enum logic [2:0] {IDLE, CHECK, ALIGN, SUB, NORM, DONE} sub_state_t;

  // Status flags that travel with a result.
  typedef struct packed {
    logic zero;
    logic underflow;
    logic overflow;
    logic qnan;
    logic snan;
    logic pinf;
    logic ninf;
  } bf16_flags_t;

  // Per-operand classification. Denormals count as zero (flush-to-zero).
  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic snan;
  } op_class_t;

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:7] == EXP_MAX) && (x[6:0] != '0);
  endfunction

endpackage

// File: rtl/bf16_special_detect.sv
// Combinational BF16 special-case classifier for an effective addition a + b
// (a subtractor feeds it the sign-flipped subtrahend).
//   a, b        : BF16 operands (b already carries its effective sign)
//   cls_a/cls_b : zero / inf / nan / snan per operand
//   spec_result : result to use when either operand is zero, inf or NaN
//   spec_flags  : flags matching spec_result
// An operand pair is special exactly when any class bit of either is set.
module bf16_special_detect
  import bf16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output op_class_t   cls_a,
  output op_class_t   cls_b,
  output logic [15:0] spec_result,
  output bf16_flags_t spec_flags
);

  function automatic op_class_t classify(input logic [15:0] x);
    op_class_t c;
    c.zero = (x[14:7] == '0);
    c.inf  = (x[14:7] == EXP_MAX) && (x[6:0] == '0);
    c.nan  = is_nan(x);
    c.snan = c.nan && !x[6];
    return c;
  endfunction

  assign cls_a = classify(a);
  assign cls_b = classify(b);

  // Precedence: NaN, then infinities, then zeros.
  always_comb begin
    spec_result = 16'h0000;
    spec_flags  = '0;
    if (cls_a.nan || cls_b.nan) begin
      spec_result     = BF16_QNAN;
      spec_flags.qnan = 1'b1;
      spec_flags.snan = cls_a.snan || cls_b.snan;
    end else if (cls_a.inf && cls_b.inf) begin
      // Opposing infinities under effective addition have no value.
      if (a[15] != b[15]) begin
        spec_result     = BF16_QNAN;
        spec_flags.qnan = 1'b1;
      end else begin
        spec_result     = a[15] ? BF16_NINF : BF16_PINF;
        spec_flags.pinf = !a[15];
        spec_flags.ninf = a[15];
      end
    end else if (cls_a.inf) begin
      spec_result     = a[15] ? BF16_NINF : BF16_PINF;
      spec_flags.pinf = !a[15];
      spec_flags.ninf = a[15];
    end else if (cls_b.inf) begin
      spec_result     = b[15] ? BF16_NINF : BF16_PINF;
      spec_flags.pinf = !b[15];
      spec_flags.ninf = b[15];
    end else if (cls_a.zero && cls_b.zero) begin
      spec_flags.zero = 1'b1;
    end else if (cls_a.zero) begin
      spec_result = b;
    end else if (cls_b.zero) begin
      spec_result = a;
    end
  end

endmodule

// File: rtl/bf16_sub_seq.sv
// Multi-cycle BF16 subtractor: result = a - b, truncating, denormals flushed.
// Alignment and normalization move one bit per cycle.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : operand handshake (in_ready only in IDLE)
//   a, b                 : minuend, subtrahend
//   out_valid/out_ready  : result handshake; result/flags held until taken
//   result + 7 flags     : difference and its status
// ALIGN_LIMIT (>=1) caps alignment cycles; larger exponent gaps flush the
// smaller operand to zero.
module bf16_sub_seq
  import bf16_pkg::*;
#(
  parameter int unsigned ALIGN_LIMIT = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        zero,
  output logic        underflow,
  output logic        overflow,
  output logic        qNaN,
  output logic        sNaN,
  output logic        positive_inf,
  output logic        negative_inf
);

  localparam int               CNT_W   = $clog2(ALIGN_LIMIT + 1);
  localparam logic [EXP_W-1:0] LIMIT_E = EXP_W'(ALIGN_LIMIT);

  sub_state_t        state;
  logic [15:0]       op_a, op_b;      // op_b holds the negated subtrahend
  logic              sign_q, eff_sub, flush_q, spec_q;
  logic [EXP_W-1:0]  exp_q;
  logic [MANT_W:0]   lg_sig, sm_sig;
  logic [MANT_W+1:0] mag;             // bit 8 is the add carry
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       result_q;
  bf16_flags_t       flags_q;
  logic              out_valid_q, in_ready_q;

  op_class_t         cls_a, cls_b;
  logic [15:0]       spec_result;
  bf16_flags_t       spec_flags;
  logic              special;

  bf16_special_detect u_detect (
    .a           (op_a),
    .b           (op_b),
    .cls_a       (cls_a),
    .cls_b       (cls_b),
    .spec_result (spec_result),
    .spec_flags  (spec_flags)
  );

  assign special = (|cls_a) || (|cls_b);

  // Magnitude ordering; ties keep a as the larger operand.
  logic             a_big;
  logic [15:0]      big_op, sml_op;
  logic [EXP_W-1:0] exp_diff;
  logic [MANT_W+1:0] mag_shl;

  assign a_big    = op_a[14:0] >= op_b[14:0];
  assign big_op   = a_big ? op_a : op_b;
  assign sml_op   = a_big ? op_b : op_a;
  assign exp_diff = big_op[14:7] - sml_op[14:7];
  assign mag_shl  = {mag[MANT_W:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      sign_q      <= 1'b0;
      eff_sub     <= 1'b0;
      flush_q     <= 1'b0;
      spec_q      <= 1'b0;
      exp_q       <= '0;
      lg_sig      <= '0;
      sm_sig      <= '0;
      mag         <= '0;
      cnt         <= '0;
      result_q    <= 16'h0000;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_a       <= a;
          op_b       <= {~b[15], b[14:0]};
          flags_q    <= '0;
          spec_q     <= 1'b0;
          in_ready_q <= 1'b0;
          state      <= CHECK;
        end
        CHECK: if (special) begin
          // Specials still pass through SUB so every result spends at
          // least two cycles in flight.
          spec_q   <= 1'b1;
          result_q <= spec_result;
          flags_q  <= spec_flags;
          state    <= SUB;
        end else begin
          sign_q  <= big_op[15];
          exp_q   <= big_op[14:7];
          lg_sig  <= {1'b1, big_op[6:0]};
          sm_sig  <= {1'b1, sml_op[6:0]};
          eff_sub <= op_a[15] ^ op_b[15];
          flush_q <= exp_diff > LIMIT_E;
          cnt     <= (exp_diff > LIMIT_E) ? CNT_W'(ALIGN_LIMIT) : CNT_W'(exp_diff);
          state   <= (exp_diff == '0) ? SUB : ALIGN;
        end
        ALIGN: begin
          sm_sig <= (cnt == CNT_W'(1) && flush_q) ? '0 : (sm_sig >> 1);
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= SUB;
        end
        SUB: if (spec_q) begin
          out_valid_q <= 1'b1;
          state       <= DONE;
        end else begin
          mag   <= eff_sub ? ({1'b0, lg_sig} - {1'b0, sm_sig})
                           : ({1'b0, lg_sig} + {1'b0, sm_sig});
          state <= NORM;
        end
        NORM: begin
          if (mag[MANT_W+1]) begin
            if (exp_q == EXP_MAX - 8'd1) begin
              result_q         <= sign_q ? BF16_NINF : BF16_PINF;
              flags_q.overflow <= 1'b1;
              flags_q.pinf     <= !sign_q;
              flags_q.ninf     <= sign_q;
            end else begin
              result_q <= {sign_q, exp_q + 8'd1, mag[MANT_W:1]};
            end
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else if (mag == '0) begin
            result_q     <= 16'h0000;
            flags_q.zero <= 1'b1;
            out_valid_q  <= 1'b1;
            state        <= DONE;
          end else if (mag[MANT_W]) begin
            result_q    <= {sign_q, exp_q, mag[MANT_W-1:0]};
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else if (exp_q == 8'd1) begin
            // A further left shift would need exponent 0.
            result_q          <= 16'h0000;
            flags_q.underflow <= 1'b1;
            flags_q.zero      <= 1'b1;
            out_valid_q       <= 1'b1;
            state             <= DONE;
          end else begin
            mag   <= mag_shl;
            exp_q <= exp_q - 8'd1;
            // Finish on the shift that lands the leading one.
            if (mag_shl[MANT_W]) begin
              result_q    <= {sign_q, exp_q - 8'd1, mag_shl[MANT_W-1:0]};
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign zero         = flags_q.zero;
  assign underflow    = flags_q.underflow;
  assign overflow     = flags_q.overflow;
  assign qNaN         = flags_q.qnan;
  assign sNaN         = flags_q.snan;
  assign positive_inf = flags_q.pinf;
  assign negative_inf = flags_q.ninf;

endmodule

// File: tb/tb_bf16_sub_seq.sv
// Scoreboard bench for bf16_sub_seq: the driver pushes hand-computed
// expectations (result, flags, latency), a monitor pops on each new result.
module tb_bf16_sub_seq;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid;
  logic [15:0] result;
  logic        zero, underflow, overflow, qNaN, sNaN, positive_inf, negative_inf;

  bf16_sub_seq #(.ALIGN_LIMIT(9)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .underflow(underflow), .overflow(overflow),
    .qNaN(qNaN), .sNaN(sNaN), .positive_inf(positive_inf),
    .negative_inf(negative_inf)
  );

  always #5 clk = ~clk;

  // Flag vector order: zero, underflow, overflow, qNaN, sNaN, +inf, -inf
  localparam logic [6:0] F_NONE = 7'b0000000, F_ZERO = 7'b1000000,
                         F_UNF  = 7'b0100000, F_OVF  = 7'b0010000,
                         F_QNAN = 7'b0001000, F_SNAN = 7'b0000100,
                         F_PINF = 7'b0000010, F_NINF = 7'b0000001;
  wire [6:0] flags = {zero, underflow, overflow, qNaN, sNaN, positive_inf, negative_inf};

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [6:0]  flg;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   mon_seen = 1'b0;
  int   checks = 0, failures = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Monitor: compare once per result presentation.
  initial begin
    forever begin
      @(negedge clk);
      if (!out_valid) mon_seen = 1'b0;
      else if (!mon_seen) begin
        mon_seen = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got result %h, expected no output", result);
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.name, "_result"},  result,          mon_e.res);
          chk({mon_e.name, "_flags"},   flags,           mon_e.flg);
          chk({mon_e.name, "_latency"}, cyc - mon_e.acc, mon_e.lat);
        end
      end
    end
  end

  task automatic send(input string nm, input logic [15:0] av, input logic [15:0] bv,
                      input logic [15:0] er, input logic [6:0] ef, input int el,
                      input bit track);
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout: got in_ready 0, expected 1", nm);
      return;
    end
    a = av;
    b = bv;
    in_valid = 1'b1;
    if (track) begin
      exp_t e;
      e.name = nm; e.res = er; e.flg = ef; e.lat = el; e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready",  in_ready,  1);
    chk("reset_result",    result,    16'h0000);
    chk("reset_flags",     flags,     F_NONE);
    rst_n = 1'b1;

    //    name            a         b         result    flags           lat
    send("basic",       16'h4040, 16'h3F80, 16'h4000, F_NONE,          4, 1);
    send("cancel",      16'h3F80, 16'h3F80, 16'h0000, F_ZERO,          3, 1);
    send("long_norm",   16'h3F81, 16'h3F80, 16'h3C00, F_NONE,          9, 1);
    send("inf_inf",     16'h7F80, 16'h7F80, 16'h7FC0, F_QNAN,          2, 1);
    send("snan",        16'h7F81, 16'h3F80, 16'h7FC0, F_QNAN | F_SNAN, 2, 1);
    send("qnan_b",      16'h3F80, 16'h7FC1, 16'h7FC0, F_QNAN,          2, 1);
    send("minus_ninf",  16'h3F80, 16'hFF80, 16'h7F80, F_PINF,          2, 1);
    send("ninf_pinf",   16'hFF80, 16'h7F80, 16'hFF80, F_NINF,          2, 1);
    send("ninf_ninf",   16'hFF80, 16'hFF80, 16'h7FC0, F_QNAN,          2, 1);
    send("overflow",    16'h7F7F, 16'hFF7F, 16'h7F80, F_OVF | F_PINF,  3, 1);
    send("underflow",   16'h0081, 16'h0080, 16'h0000, F_UNF | F_ZERO,  3, 1);
    send("align_limit", 16'h4B00, 16'h3F80, 16'h4B00, F_NONE,         12, 1);
    send("neg_result",  16'h3F80, 16'h4040, 16'hC000, F_NONE,          4, 1);
    send("eff_add",     16'h3F80, 16'hBF80, 16'h4000, F_NONE,          3, 1);
    send("zero_a",      16'h0000, 16'h4040, 16'hC040, F_NONE,          2, 1);
    send("zero_b",      16'h4040, 16'h0000, 16'h4040, F_NONE,          2, 1);
    send("denorm_ftz",  16'h0001, 16'h0000, 16'h0000, F_ZERO,          2, 1);
    drain();

    // Backpressure: result must hold and new operands must be ignored.
    out_ready = 1'b0;
    send("hold", 16'h4040, 16'h3F80, 16'h4000, F_NONE, 4, 1);
    g = 0;
    while (!out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("hold_reached_valid", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 16'h3F80;
      b = 16'h3F80;
      @(negedge clk);
      chk("hold_result",    result,    16'h4000);
      chk("hold_flags",     flags,     F_NONE);
      chk("hold_in_ready",  in_ready,  0);
      chk("hold_out_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready",  in_ready,  1);
    repeat (15) @(negedge clk);
    chk("ignored_no_output", out_valid, 0);

    // Reset in the middle of ALIGN, then a clean operation.
    send("abort", 16'h4B00, 16'h3F80, 16'h0000, F_NONE, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_in_ready",  in_ready,  1);
    chk("midreset_result",    result,    16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    send("after_reset", 16'h4040, 16'h3F80, 16'h4000, F_NONE, 4, 1);
    drain();
    repeat (15) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
